// File: rtl/miriscv_data_arb.sv
// Two-master arbiter for the shared RAM data port. Grant is combinational in the request cycle and the response follows one cycle later.
// A master that loses arbitration keeps its request and attributes stable until it is granted.
module miriscv_data_arb #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int FIXED_PRIO = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  logic                  m0_req_i,
    input  logic                  m0_we_i,
    input  logic [DATA_W/8-1:0]   m0_be_i,
    input  logic [ADDR_W-1:0]     m0_addr_i,
    input  logic [DATA_W-1:0]     m0_wdata_i,
    output logic                  m0_gnt_o,
    output logic                  m0_rvalid_o,
    output logic [DATA_W-1:0]     m0_rdata_o,

    input  logic                  m1_req_i,
    input  logic                  m1_we_i,
    input  logic [DATA_W/8-1:0]   m1_be_i,
    input  logic [ADDR_W-1:0]     m1_addr_i,
    input  logic [DATA_W-1:0]     m1_wdata_i,
    output logic                  m1_gnt_o,
    output logic                  m1_rvalid_o,
    output logic [DATA_W-1:0]     m1_rdata_o,

    output logic                  ram_req_o,
    output logic                  ram_we_o,
    output logic [DATA_W/8-1:0]   ram_be_o,
    output logic [ADDR_W-1:0]     ram_addr_o,
    output logic [DATA_W-1:0]     ram_wdata_o,
    input  logic [DATA_W-1:0]     ram_rdata_i
);

    logic pick1;
    logic gnt0;
    logic gnt1;
    logic any_gnt;
    logic last_gnt;
    logic resp_valid;
    logic resp_id;

    // last_gnt = 1 means master 1 was granted most recently, so master 0 wins the next tie.
    always_comb begin
        if (m0_req_i && m1_req_i) begin
            pick1 = (FIXED_PRIO != 0) ? 1'b0 : ~last_gnt;
        end else begin
            pick1 = m1_req_i;
        end
        gnt0    = ~rst_i & m0_req_i & ~pick1;
        gnt1    = ~rst_i & m1_req_i &  pick1;
        any_gnt = gnt0 | gnt1;
    end

    assign m0_gnt_o    = gnt0;
    assign m1_gnt_o    = gnt1;
    assign ram_req_o   = any_gnt;
    assign ram_we_o    = gnt1 ? m1_we_i    : (gnt0 & m0_we_i);
    assign ram_be_o    = gnt1 ? m1_be_i    : m0_be_i;
    assign ram_addr_o  = gnt1 ? m1_addr_i  : m0_addr_i;
    assign ram_wdata_o = gnt1 ? m1_wdata_i : m0_wdata_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            resp_valid <= 1'b0;
            resp_id    <= 1'b0;
            last_gnt   <= 1'b0;
        end else begin
            resp_valid <= any_gnt;
            resp_id    <= gnt1;
            if (any_gnt) begin
                last_gnt <= gnt1;
            end
        end
    end

    // A response registered just before reset rose is dropped while reset is held.
    assign m0_rvalid_o = resp_valid & ~resp_id & ~rst_i;
    assign m1_rvalid_o = resp_valid &  resp_id & ~rst_i;
    assign m0_rdata_o  = ram_rdata_i;
    assign m1_rdata_o  = ram_rdata_i;

endmodule
